// File: rtl/data_sync_tx_pkg.sv
// data_sync_tx_pkg: shared config and state encoding for the bus-crossing sender
//   WIDTH                    bus width shared with the destination synchronizer
//   DATA_SYNC_STAGES         destination-side enable synchronizer depth
//   DATA_SYNC_TX_ACK_STAGES  sender-side ack synchronizer depth (>= 2)
//   DATA_SYNC_TX_TIMEOUT     ack watchdog limit in cycles (0 disables)
package data_sync_tx_pkg;
    localparam int WIDTH = 8;
    localparam int DATA_SYNC_STAGES = 2;
    localparam int DATA_SYNC_TX_ACK_STAGES = 2;
    localparam int DATA_SYNC_TX_TIMEOUT = 255;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SETUP = 2'd1;
    localparam state_t ST_REQ = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;
endpackage

// File: rtl/data_sync_tx_if.sv
// data_sync_tx_if: cross-domain bus between sender and destination synchronizer
//   Bus_Out  held data word, sender -> destination
//   Bus_En   request level, sender -> destination
//   Ack_In   destination's synchronized enable, fed back to the sender
interface data_sync_tx_if #(parameter int WIDTH = data_sync_tx_pkg::WIDTH);
    logic [WIDTH-1:0] Bus_Out;
    logic Bus_En;
    logic Ack_In;
    modport master (output Bus_Out, Bus_En, input Ack_In);
    modport slave (input Bus_Out, Bus_En, output Ack_In);
endinterface

// File: rtl/data_sync_tx_bit_sync.sv
// bit_sync: N-stage single-bit synchronizer with synchronous active-high reset
//   CLK  destination clock
//   RST  clears every stage
//   D    asynchronous input bit
//   Q    synchronized output bit
module bit_sync #(parameter int STAGES = 2) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge CLK)
        sr <= RST ? '0 : {sr[STAGES-2:0], D};
    assign Q = sr[STAGES-1];
endmodule

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-domain sender running a 4-phase req/ack over a held bus
//   CLK, RST     source clock, synchronous active-high reset
//   Data_In      word to transfer; captured when Data_Valid & Data_Ready
//   Data_Valid   producer has a word
//   Data_Ready   high only in IDLE
//   Busy         not IDLE
//   Done_Pulse   one-cycle pulse on clean completion
//   Timeout_Err  sticky watchdog error; Err_Clr clears it (set wins)
//   bus          master side of the crossing bus (Bus_Out, Bus_En, Ack_In)
module data_sync_tx
    import data_sync_tx_pkg::*;
#(
    parameter int WIDTH = data_sync_tx_pkg::WIDTH,
    parameter int ACK_SYNC_STAGES = DATA_SYNC_TX_ACK_STAGES,
    parameter int TIMEOUT_CYCLES = DATA_SYNC_TX_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Data_Valid,
    output logic             Data_Ready,
    output logic             Busy,
    output logic             Done_Pulse,
    output logic             Timeout_Err,
    input  logic             Err_Clr,
    data_sync_tx_if.master   bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
    state_t state, state_n;
    logic [WD_W-1:0] wd, wd_n;
    logic ack_s, expire, bus_en_n, done_n, err_set, capture;

    bit_sync #(.STAGES(ACK_SYNC_STAGES)) u_ack_sync (
        .CLK(CLK),
        .RST(RST),
        .D(bus.Ack_In),
        .Q(ack_s)
    );

    // wd counts completed cycles in the current ack phase, so the phase
    // expires on its TIMEOUT_CYCLES-th edge
    assign expire = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            wd <= '0;
            bus.Bus_Out <= '0;
            bus.Bus_En <= 1'b0;
            Done_Pulse <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            state <= state_n;
            wd <= wd_n;
            if (capture)
                bus.Bus_Out <= Data_In;
            bus.Bus_En <= bus_en_n;
            Done_Pulse <= done_n;
            Timeout_Err <= err_set || (Timeout_Err && !Err_Clr);
        end
    end

    // ack_s seen in IDLE/SETUP is stale and deliberately ignored
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = Data_Valid ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_n = ST_REQ;
            ST_REQ:   state_n = ack_s ? ST_RELEASE : expire ? ST_IDLE : ST_REQ;
            default:  state_n = (!ack_s || expire) ? ST_IDLE : ST_RELEASE;
        endcase
    end

    always_comb begin
        capture = (state == ST_IDLE) && Data_Valid;
        bus_en_n = (state_n == ST_REQ);
        done_n = (state == ST_RELEASE) && !ack_s;
        err_set = expire && (((state == ST_REQ) && !ack_s) || ((state == ST_RELEASE) && ack_s));
        wd_n = ((state_n == state) && (state == ST_REQ || state == ST_RELEASE)) ? wd + 1'b1 : '0;
    end

    assign Data_Ready = (state == ST_IDLE);
    assign Busy = (state != ST_IDLE);
endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed self-checking bench for data_sync_tx
//   Ack_In is a 4-cycle delayed copy of Bus_En, or forced 0/1 per step.
module tb_data_sync_tx;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [7:0] Data_In = '0;
    logic Data_Valid = 1'b0;
    logic Err_Clr = 1'b0;
    logic Data_Ready, Busy, Done_Pulse, Timeout_Err;
    logic [3:0] dly = '0;
    int ack_mode = 0;
    int vectors = 0;
    int miscompares = 0;

    data_sync_tx_if #(.WIDTH(8)) bus ();

    data_sync_tx #(.WIDTH(8), .ACK_SYNC_STAGES(2), .TIMEOUT_CYCLES(10)) dut (
        .CLK(CLK),
        .RST(RST),
        .Data_In(Data_In),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .Busy(Busy),
        .Done_Pulse(Done_Pulse),
        .Timeout_Err(Timeout_Err),
        .Err_Clr(Err_Clr),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // destination model: ack mirrors Bus_En four cycles later
    always @(posedge CLK) dly <= RST ? 4'b0 : {dly[2:0], bus.Bus_En};
    assign bus.Ack_In = (ack_mode == 0) ? dly[3] : (ack_mode == 2);

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, rises, dones;
        logic prev_en, stable;
        repeat (3) tick;
        chk("rst_en", bus.Bus_En, 0);
        chk("rst_out", bus.Bus_Out, 0);
        chk("rst_done", Done_Pulse, 0);
        chk("rst_err", Timeout_Err, 0);
        RST = 1'b0;
        tick;
        chk("rst_ready", Data_Ready, 1);
        chk("rst_busy", Busy, 0);

        Data_In = 8'hA5;
        Data_Valid = 1'b1;
        tick;
        Data_Valid = 1'b0;
        chk("a5_capture", bus.Bus_Out, 8'hA5);
        chk("a5_busy", Busy, 1);
        chk("a5_setup_en", bus.Bus_En, 0);
        tick;
        chk("a5_req_en", bus.Bus_En, 1);
        n = 2;
        stable = 1'b1;
        while (!Done_Pulse && n < 40) begin
            tick;
            n++;
            if (bus.Bus_Out !== 8'hA5) stable = 1'b0;
        end
        chk("a5_latency", n, 16);
        chk("a5_held", stable, 1);
        dones = 0;
        repeat (5) begin
            tick;
            if (Done_Pulse) dones++;
        end
        chk("a5_single_done", dones, 0);

        Data_In = 8'h3C;
        Data_Valid = 1'b1;
        tick;
        Data_In = 8'h81;
        n = 1;
        rises = 0;
        prev_en = 1'b0;
        stable = 1'b1;
        while (!Done_Pulse && n < 40) begin
            tick;
            n++;
            if (bus.Bus_En && !prev_en) rises++;
            prev_en = bus.Bus_En;
            if (bus.Bus_Out !== 8'h3C) stable = 1'b0;
        end
        chk("b2b_lat1", n, 16);
        chk("b2b_ready_on_done", Data_Ready, 1);
        chk("b2b_held1", stable, 1);
        tick;
        Data_Valid = 1'b0;
        chk("b2b_capture2", bus.Bus_Out, 8'h81);
        chk("b2b_busy2", Busy, 1);
        n = 1;
        stable = 1'b1;
        while (!Done_Pulse && n < 40) begin
            tick;
            n++;
            if (bus.Bus_En && !prev_en) rises++;
            prev_en = bus.Bus_En;
            if (bus.Bus_Out !== 8'h81) stable = 1'b0;
        end
        chk("b2b_lat2", n, 16);
        chk("b2b_held2", stable, 1);
        chk("b2b_en_rises", rises, 2);

        tick;
        ack_mode = 1;
        Data_In = 8'h55;
        Data_Valid = 1'b1;
        tick;
        Data_Valid = 1'b0;
        dones = 0;
        repeat (10) begin
            tick;
            if (Done_Pulse) dones++;
        end
        chk("to_req_err_pre", Timeout_Err, 0);
        chk("to_req_en_pre", bus.Bus_En, 1);
        tick;
        chk("to_req_err", Timeout_Err, 1);
        chk("to_req_en", bus.Bus_En, 0);
        chk("to_req_idle", Busy, 0);
        chk("to_req_no_done", dones + int'(Done_Pulse), 0);
        Err_Clr = 1'b1;
        tick;
        Err_Clr = 1'b0;
        chk("to_clear", Timeout_Err, 0);
        ack_mode = 0;
        repeat (8) tick;

        ack_mode = 2;
        Err_Clr = 1'b1;
        Data_In = 8'h99;
        Data_Valid = 1'b1;
        tick;
        Data_Valid = 1'b0;
        n = 1;
        dones = 0;
        while (!Timeout_Err && n < 40) begin
            tick;
            n++;
            if (Done_Pulse) dones++;
        end
        chk("to_rel_latency", n, 13);
        chk("to_rel_en", bus.Bus_En, 0);
        chk("to_rel_idle", Busy, 0);
        chk("to_rel_no_done", dones, 0);
        tick;
        chk("to_rel_clear", Timeout_Err, 0);
        Err_Clr = 1'b0;
        ack_mode = 0;
        repeat (8) tick;

        Data_In = 8'h77;
        Data_Valid = 1'b1;
        tick;
        Data_Valid = 1'b0;
        tick;
        chk("rst_mid_req_en", bus.Bus_En, 1);
        RST = 1'b1;
        tick;
        chk("rst_mid_en", bus.Bus_En, 0);
        chk("rst_mid_out", bus.Bus_Out, 0);
        chk("rst_mid_done", Done_Pulse, 0);
        RST = 1'b0;
        tick;
        chk("rst_mid_ready", Data_Ready, 1);
        dones = 0;
        repeat (10) begin
            tick;
            if (Done_Pulse) dones++;
        end
        chk("rst_mid_no_done", dones, 0);

        ack_mode = 2;
        tick;
        ack_mode = 0;
        Data_In = 8'hFF;
        Data_Valid = 1'b1;
        tick;
        Data_Valid = 1'b0;
        tick;
        chk("glitch_req_en", bus.Bus_En, 1);
        n = 2;
        stable = 1'b1;
        while (!Done_Pulse && n < 40) begin
            tick;
            n++;
            if (bus.Bus_Out !== 8'hFF) stable = 1'b0;
        end
        chk("glitch_latency", n, 16);
        chk("glitch_data", bus.Bus_Out, 8'hFF);
        chk("glitch_held", stable, 1);
        chk("glitch_no_err", Timeout_Err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
- Source-domain sender for a multi-clock bus crossing. Pairs with the destination-domain data synchronizer, which captures the bus on the rising edge of its synchronized enable.
- Latches a word from a local valid/ready producer and holds it on Bus_Out for the whole transfer.
- Runs a 4-phase request/acknowledge handshake with Bus_En. Ack_In is the destination's synchronized copy of Bus_En, fed back across domains.
- Guarantees bus stability, which makes fast-to-slow crossings safe. Adds a watchdog on the acknowledge.

Parameters:
- WIDTH, 8, bus width; comes from the shared config.
- ACK_SYNC_STAGES, 2, number of flops synchronizing Ack_In; must be >= 2.
- TIMEOUT_CYCLES, 255, maximum cycles to wait in either ack phase; 0 disables the watchdog.

Ports:
- CLK  in  1  source-domain clock.
- RST  in  1  reset; synchronous, active-high, sampled on rising CLK.
- Data_In  in  WIDTH  word to transfer.
- Data_Valid  in  1  producer has a word.
- Data_Ready  out  1  high only in IDLE; a transfer starts when Valid&Ready at a rising edge.
- Ack_In  in  1  destination's synchronized enable; asynchronous to CLK.
- Bus_Out  out  WIDTH  held word; drives the destination's Bus_IN.
- Bus_En  out  1  request level; drives the destination's Bus_En.
- Busy  out  1  not IDLE.
- Done_Pulse  out  1  one-cycle pulse when a transfer completes cleanly.
- Timeout_Err  out  1  sticky; set on watchdog expiry.
- Err_Clr  in  1  clears Timeout_Err.

Behaviour:
- Reset (RST=1 at an edge):
  - State=IDLE.
  - Bus_Out=0, Bus_En=0, Done_Pulse=0, Timeout_Err=0.
  - Ack sync chain cleared; watchdog count=0.
  - Data_Ready=1 from the first edge after reset deasserts.
  - Reset mid-transfer aborts immediately: Bus_En drops and no Done_Pulse is issued.
- Ack_In passes through ACK_SYNC_STAGES flops, giving ack_s. All state decisions use ack_s only.
- All outputs are registered except Data_Ready and Busy, which are decoded from the state register.
- IDLE:
  - Valid&Ready: Bus_Out<=Data_In, go to SETUP.
  - Otherwise Bus_Out holds its last value.
- SETUP (exactly 1 cycle):
  - Bus_Out is stable; Bus_En still 0.
  - Next state is REQ; Bus_En<=1 on that edge.
- REQ:
  - Bus_En=1; watchdog increments each cycle.
  - ack_s=1: Bus_En<=0, watchdog<=0, go to RELEASE.
- RELEASE:
  - Bus_En=0; Bus_Out is still held.
  - ack_s=0: Done_Pulse<=1 for one cycle, go to IDLE.
- Bus_Out must never change while Busy=1. It changes only on a capture edge.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts in REQ and RELEASE; restarts at 0 on each phase entry.
  - Reaching TIMEOUT_CYCLES: Timeout_Err<=1, Bus_En<=0, go to IDLE, no Done_Pulse.
- ack_s=1 in IDLE or SETUP (stale ack): ignored; the REQ phase is still entered.
- Err_Clr and expiry on the same edge: set wins.
- Latency with a destination of equal clock and 2+2 sync stages:
  - Bus_En rises 2 cycles after capture.
  - ack_s rises >= ACK_SYNC_STAGES + dest sync latency later.
  - Minimum transfer is about 2 + 2·(ACK_SYNC_STAGES + D) cycles.
- Back-to-back:
  - Data_Ready returns on the cycle Done_Pulse is high.
  - A new capture may occur on the edge ending that cycle.

Decomposition:
- Shared config: add DATA_SYNC_TX_ACK_STAGES and DATA_SYNC_TX_TIMEOUT to the existing config macro file alongside WIDTH and DATA_SYNC_STAGES.
- State encoding (IDLE, SETUP, REQ, RELEASE) as localparams.
- One sub-module: bit_sync.
  - Generic N-stage single-bit synchronizer with synchronous active-high reset.
  - Instantiated for Ack_In and reusable elsewhere.

Test Plan:
- Reset hold 3 cycles, then Valid with Data_In=8'hA5, Ack_In mirrored by a 4-cycle-delay model.
  - Bus_Out=A5 one edge after capture; Bus_En rises 1 cycle later.
  - Single Done_Pulse; Bus_Out stays A5 throughout.
- Two words 8'h3C, 8'h81 with Valid held high.
  - Second capture occurs exactly on the Done_Pulse cycle.
  - Bus_En goes through two full high/low cycles; no overlap.
- Ack_In tied 0, TIMEOUT_CYCLES=10.
  - Timeout_Err sets after 10 REQ cycles; Bus_En=0, state IDLE, no Done_Pulse.
  - Err_Clr=1 clears it next edge.
- Ack_In stuck 1 after the REQ phase.
  - RELEASE times out; Timeout_Err=1.
- RST asserted while in REQ.
  - Next edge: Bus_En=0, Bus_Out=0, Data_Ready=1 after release, no Done_Pulse.
- Ack_In glitch (1-cycle high pulse) in IDLE before Valid.
  - Transfer still waits for a genuine ack in REQ and completes normally with data 8'hFF.
